// File: rtl/gray_pkg.sv
// Shared mode encodings and whole-word Gray/binary reference functions.
package gray_pkg;

  localparam logic MODE_G2B = 1'b0;
  localparam logic MODE_B2G = 1'b1;

  localparam int unsigned MODEL_W = 32;
  typedef logic [MODEL_W-1:0] model_word_t;

  function automatic model_word_t width_mask(input int unsigned w);
    if (w >= MODEL_W) return '1;
    return (model_word_t'(1) << w) - model_word_t'(1);
  endfunction

  // Prefix-XOR from the MSB down by log-step doubling over a w-bit word.
  function automatic model_word_t gray2bin_full(input model_word_t g, input int unsigned w);
    model_word_t b;
    b = g & width_mask(w);
    for (int unsigned s = 1; s < MODEL_W; s = s << 1) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

  function automatic model_word_t bin2gray(input model_word_t b, input int unsigned w);
    model_word_t m;
    m = b & width_mask(w);
    return m ^ (m >> 1);
  endfunction

endpackage

// File: rtl/gray_pipe_stage.sv
// One pipeline slot: valid/data/mode register with local advance and the
// Gray-to-binary resolution of bits [HI:LO] (empty range = pure register).
module gray_pipe_stage
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int          HI     = 7,
  parameter int          LO     = 0,
  parameter bit          B2G_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             mode_i,
  input  logic             adv_next_i,
  output logic             adv_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             mode_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             mode_q;

  // Bits above HI are already binary, so bit HI+1 is the carry-in for this chunk.
  function automatic logic [WIDTH-1:0] resolve_chunk(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = x;
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      if (i <= HI && i >= LO) r[i] = r[i+1] ^ x[i];
    end
    return r;
  endfunction

  assign adv_o = ~valid_q | adv_next_i;

  always_comb begin
    data_d = data_i;
    if (mode_i == MODE_G2B) begin
      data_d = resolve_chunk(data_i);
    end else if (B2G_EN) begin
      data_d = data_i ^ (data_i >> 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mode_q  <= 1'b0;
    end else if (adv_o) begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= data_d;
        mode_q <= mode_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign mode_o  = mode_q;

endmodule

// File: rtl/gray_code_pipe.sv
// Pipelined bidirectional Gray/binary converter with valid/ready on both sides;
// Gray-to-binary is resolved MSB chunk first, one chunk per stage.
module gray_code_pipe
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             busy
);

  localparam int unsigned CHUNK = (WIDTH + STAGES - 1) / STAGES;

  logic [STAGES-1:0]            vld;
  logic [STAGES-1:0]            md;
  logic [STAGES-1:0][WIDTH-1:0] dat;

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    localparam int HI     = int'(WIDTH) - 1 - k * int'(CHUNK);
    localparam int LO_RAW = int'(WIDTH) - (k + 1) * int'(CHUNK);
    localparam int LO     = (LO_RAW < 0) ? 0 : LO_RAW;

    logic             v_in;
    logic             m_in;
    logic [WIDTH-1:0] d_in;
    logic             a_next;
    logic             adv_w;

    if (k == 0) begin : g_src
      assign v_in = in_valid;
      assign d_in = in_data;
      assign m_in = in_mode;
    end else begin : g_chain
      assign v_in = vld[k-1];
      assign d_in = dat[k-1];
      assign m_in = md[k-1];
    end

    // Ready ripples back combinationally so a full pipe still moves every cycle.
    if (k == int'(STAGES) - 1) begin : g_last
      assign a_next = out_ready;
    end else begin : g_mid
      assign a_next = g_stage[k+1].adv_w;
    end

    gray_pipe_stage #(
      .WIDTH  (WIDTH),
      .HI     (HI),
      .LO     (LO),
      .B2G_EN (k == 0 ? 1'b1 : 1'b0)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .valid_i    (v_in),
      .data_i     (d_in),
      .mode_i     (m_in),
      .adv_next_i (a_next),
      .adv_o      (adv_w),
      .valid_o    (vld[k]),
      .data_o     (dat[k]),
      .mode_o     (md[k])
    );
  end

  assign in_ready  = g_stage[0].adv_w;
  assign out_valid = vld[STAGES-1];
  assign out_data  = dat[STAGES-1];
  assign out_mode  = md[STAGES-1];
  assign busy      = |vld;

endmodule

// File: tb/tb_gray_code_pipe.sv
// Directed and streaming checks of gray_code_pipe over several parameter sets.
module tb_gray_code_pipe;
  import gray_pkg::*;

  logic       clk, rst, in_valid, in_mode, out_ready;
  logic [7:0] in_data;
  int         sel;
  int         total, bad;

  // sel 0: W4 S2, 1: W8 S3, 2: W5 S2, 3: W4 S4
  logic       a_iv, a_ir, a_ov, a_om, a_busy;
  logic [3:0] a_od;
  logic       b_iv, b_ir, b_ov, b_om, b_busy;
  logic [7:0] b_od;
  logic       c_iv, c_ir, c_ov, c_om, c_busy;
  logic [4:0] c_od;
  logic       d_iv, d_ir, d_ov, d_om, d_busy;
  logic [3:0] d_od;

  assign a_iv = in_valid && (sel == 0);
  assign b_iv = in_valid && (sel == 1);
  assign c_iv = in_valid && (sel == 2);
  assign d_iv = in_valid && (sel == 3);

  gray_code_pipe #(.WIDTH(4), .STAGES(2)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(in_data[3:0]),
    .in_mode(in_mode), .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od),
    .out_mode(a_om), .busy(a_busy));
  gray_code_pipe #(.WIDTH(8), .STAGES(3)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(in_data),
    .in_mode(in_mode), .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od),
    .out_mode(b_om), .busy(b_busy));
  gray_code_pipe #(.WIDTH(5), .STAGES(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(in_data[4:0]),
    .in_mode(in_mode), .out_valid(c_ov), .out_ready(out_ready), .out_data(c_od),
    .out_mode(c_om), .busy(c_busy));
  gray_code_pipe #(.WIDTH(4), .STAGES(4)) u_d (
    .clk(clk), .rst(rst), .in_valid(d_iv), .in_ready(d_ir), .in_data(in_data[3:0]),
    .in_mode(in_mode), .out_valid(d_ov), .out_ready(out_ready), .out_data(d_od),
    .out_mode(d_om), .busy(d_busy));

  logic       cur_ir, cur_ov, cur_om, cur_busy;
  logic [7:0] cur_od;

  always_comb begin
    cur_ir = 1'b0; cur_ov = 1'b0; cur_om = 1'b0; cur_busy = 1'b0; cur_od = 8'h00;
    case (sel)
      0: begin cur_ir = a_ir; cur_ov = a_ov; cur_om = a_om; cur_busy = a_busy; cur_od = 8'(a_od); end
      1: begin cur_ir = b_ir; cur_ov = b_ov; cur_om = b_om; cur_busy = b_busy; cur_od = b_od; end
      2: begin cur_ir = c_ir; cur_ov = c_ov; cur_om = c_om; cur_busy = c_busy; cur_od = 8'(c_od); end
      default: begin cur_ir = d_ir; cur_ov = d_ov; cur_om = d_om; cur_busy = d_busy; cur_od = 8'(d_od); end
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      total++;
      if (cur_ov !== 1'b0 || cur_busy !== 1'b0) begin
        bad++; $display("FAIL reset_valid dut=%0d got ov=%b busy=%b want 0 0", s, cur_ov, cur_busy);
      end
      total++;
      if (cur_od !== 8'h00 || cur_om !== 1'b0) begin
        bad++; $display("FAIL reset_data dut=%0d got data=%h mode=%b want 00 0", s, cur_od, cur_om);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      total++;
      if (cur_ir !== 1'b1) begin
        bad++; $display("FAIL reset_in_ready dut=%0d got=%b want=1", s, cur_ir);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_g2b_directed;
    logic [3:0] gin [5];
    logic [3:0] exp [5];
    int nout;
    gin = '{4'b1110, 4'b0100, 4'b0111, 4'b1010, 4'b1000};
    exp = '{4'b1011, 4'b0111, 4'b0101, 4'b1100, 4'b1111};
    sel = 0; nout = 0; out_ready = 1'b1; in_mode = MODE_G2B;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 5);
      in_data  = (c < 5) ? 8'(gin[c]) : 8'h00;
      @(negedge clk);
      if (c < 5) begin
        total++;
        if (cur_ir !== 1'b1) begin bad++; $display("FAIL g2b_in_ready cycle=%0d got=%b want=1", c, cur_ir); end
      end
      if (cur_ov === 1'b1) begin
        total++;
        if (nout >= 5 || cur_od !== 8'(exp[nout]) || cur_om !== 1'b0 || c != nout + 2) begin
          bad++;
          $display("FAIL g2b_out idx=%0d got data=%h mode=%b cycle=%0d want data=%h mode=0 cycle=%0d",
                   nout, cur_od, cur_om, c, (nout < 5) ? exp[nout] : 4'h0, nout + 2);
        end
        nout++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++;
    if (nout != 5) begin bad++; $display("FAIL g2b_count got=%0d want=5", nout); end
  endtask

  task automatic test_b2g_directed;
    logic [3:0] bin [2];
    logic [3:0] exp [2];
    int nout;
    bin = '{4'b1011, 4'b1111};
    exp = '{4'b1110, 4'b1000};
    sel = 0; nout = 0; out_ready = 1'b1; in_mode = MODE_B2G;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c < 2);
      in_data  = (c < 2) ? 8'(bin[c]) : 8'h00;
      @(negedge clk);
      if (cur_ov === 1'b1) begin
        total++;
        if (nout >= 2 || cur_od !== 8'(exp[nout]) || cur_om !== 1'b1 || c != nout + 2) begin
          bad++;
          $display("FAIL b2g_out idx=%0d got data=%h mode=%b cycle=%0d want data=%h mode=1 cycle=%0d",
                   nout, cur_od, cur_om, c, (nout < 2) ? exp[nout] : 4'h0, nout + 2);
        end
        nout++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++;
    if (nout != 2) begin bad++; $display("FAIL b2g_count got=%0d want=2", nout); end
  endtask

  task automatic test_backpressure;
    logic [7:0] wds [5];
    logic       mds [5];
    logic [7:0] exp [3];
    int acc, nout;
    wds = '{8'h3C, 8'hA5, 8'h81, 8'h55, 8'h66};
    mds = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp = '{8'h28, 8'hF7, 8'hFE};
    sel = 1; acc = 0; out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      in_data  = wds[acc];
      in_mode  = mds[acc];
      @(negedge clk);
      if (c >= 3) begin
        total++;
        if (cur_ir !== 1'b0 || cur_ov !== 1'b1 || cur_od !== 8'h28 || cur_om !== 1'b0) begin
          bad++;
          $display("FAIL bp_hold cycle=%0d got ir=%b ov=%b data=%h mode=%b want ir=0 ov=1 data=28 mode=0",
                   c, cur_ir, cur_ov, cur_od, cur_om);
        end
      end
      if (cur_ir === 1'b1) acc++;
      @(posedge clk); #1;
    end
    total++;
    if (acc != 3 || cur_busy !== 1'b1) begin
      bad++; $display("FAIL bp_fill got accepts=%0d busy=%b want 3 1", acc, cur_busy);
    end
    in_valid = 1'b0; out_ready = 1'b1; nout = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (cur_ov === 1'b1) begin
        total++;
        if (nout >= 3 || cur_od !== exp[nout] || cur_om !== mds[nout]) begin
          bad++;
          $display("FAIL bp_drain idx=%0d got data=%h mode=%b want data=%h", nout, cur_od, cur_om,
                   (nout < 3) ? exp[nout] : 8'h00);
        end
        nout++;
      end
      @(posedge clk); #1;
    end
    total++;
    if (nout != 3 || cur_busy !== 1'b0) begin
      bad++; $display("FAIL bp_drain_count got=%0d busy=%b want 3 0", nout, cur_busy);
    end
  endtask

  task automatic test_mixed_random;
    logic [8:0] q [$];
    logic [8:0] e;
    logic [7:0] ev;
    logic       acc;
    int sent, nout;
    sel = 1; sent = 0; nout = 0;
    in_valid = 1'b1; in_data = 8'($urandom); in_mode = MODE_G2B;
    for (int cyc = 0; cyc < 6000 && nout < 1000; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_valid && cur_ir;
      if (cur_ov === 1'b1 && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL mixed_extra idx=%0d got data=%h want no output", nout, cur_od);
        end else begin
          e = q.pop_front();
          if (cur_od !== e[7:0] || cur_om !== e[8]) begin
            bad++;
            $display("FAIL mixed_out idx=%0d got data=%h mode=%b want data=%h mode=%b",
                     nout, cur_od, cur_om, e[7:0], e[8]);
          end
        end
        nout++;
      end
      if (acc) begin
        ev = in_mode ? 8'(bin2gray(MODEL_W'(in_data), 8)) : 8'(gray2bin_full(MODEL_W'(in_data), 8));
        q.push_back({in_mode, ev});
      end
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent < 1000) begin
          in_data = 8'($urandom);
          in_mode = 1'(sent % 2);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++;
    if (nout != 1000) begin bad++; $display("FAIL mixed_count got=%0d want=1000", nout); end
  endtask

  task automatic test_reset_midflight;
    logic seen;
    sel = 1; out_ready = 1'b0; in_mode = MODE_G2B;
    in_valid = 1'b1; in_data = 8'h12;
    @(posedge clk); #1;
    in_data = 8'h34;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (cur_ov !== 1'b1 || cur_busy !== 1'b1) begin
      bad++; $display("FAIL rstmid_pre got ov=%b busy=%b want 1 1", cur_ov, cur_busy);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (cur_ov !== 1'b0 || cur_busy !== 1'b0 || cur_od !== 8'h00) begin
      bad++; $display("FAIL rstmid_async got ov=%b busy=%b data=%h want 0 0 00", cur_ov, cur_busy, cur_od);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hFF; seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        total++;
        if (cur_ir !== 1'b1) begin bad++; $display("FAIL rstmid_accept got=%b want=1", cur_ir); end
      end
      if (cur_ov === 1'b1) begin
        total++;
        if (seen || c != 3 || cur_od !== 8'hAA || cur_om !== 1'b0) begin
          bad++; $display("FAIL rstmid_out got data=%h cycle=%0d want data=aa cycle=3", cur_od, c);
        end
        seen = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL rstmid_timeout got no output want aa"); end
  endtask

  task automatic test_exhaustive;
    int unsigned w;
    int lat, n, nout;
    logic [7:0] ev;
    out_ready = 1'b1;
    for (int s = 2; s <= 3; s++) begin
      for (int m = 0; m < 2; m++) begin
        sel = s; w = (s == 2) ? 5 : 4; lat = (s == 2) ? 2 : 4; n = 1 << w; nout = 0;
        in_mode = 1'(m);
        for (int c = 0; c < n + lat + 2; c++) begin
          in_valid = (c < n);
          in_data  = 8'(c);
          @(negedge clk);
          if (cur_ov === 1'b1) begin
            ev = (m == 0) ? 8'(gray2bin_full(MODEL_W'(nout), w)) : 8'(bin2gray(MODEL_W'(nout), w));
            total++;
            if (cur_od !== ev || cur_om !== 1'(m) || c != nout + lat) begin
              bad++;
              $display("FAIL exh dut=%0d mode=%0d in=%0d got data=%h cycle=%0d want data=%h cycle=%0d",
                       s, m, nout, cur_od, c, ev, nout + lat);
            end
            nout++;
          end
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
        total++;
        if (nout != n) begin bad++; $display("FAIL exh_count dut=%0d mode=%0d got=%0d want=%0d", s, m, nout, n); end
      end
    end
  endtask

  task automatic test_round_trip;
    logic [7:0] gmem [256];
    int nout;
    sel = 1; out_ready = 1'b1; nout = 0; in_mode = MODE_B2G;
    for (int c = 0; c < 262; c++) begin
      in_valid = (c < 256);
      in_data  = 8'(c);
      @(negedge clk);
      if (cur_ov === 1'b1) begin
        if (nout < 256) gmem[nout] = cur_od;
        nout++;
      end
      @(posedge clk); #1;
    end
    total++;
    if (nout != 256) begin bad++; $display("FAIL rt_fwd_count got=%0d want=256", nout); end
    nout = 0; in_mode = MODE_G2B;
    for (int c = 0; c < 262; c++) begin
      in_valid = (c < 256);
      in_data  = (c < 256) ? gmem[c] : 8'h00;
      @(negedge clk);
      if (cur_ov === 1'b1) begin
        total++;
        if (cur_od !== 8'(nout) || cur_om !== 1'b0) begin
          bad++; $display("FAIL rt_back got=%h mode=%b want=%h mode=0", cur_od, cur_om, 8'(nout));
        end
        nout++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++;
    if (nout != 256) begin bad++; $display("FAIL rt_back_count got=%0d want=256", nout); end
  endtask

  initial begin
    total = 0; bad = 0; sel = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_mode = 1'b0; out_ready = 1'b0;
    test_reset;
    test_g2b_directed;
    test_b2g_directed;
    test_backpressure;
    test_mixed_random;
    test_reset_midflight;
    test_exhaustive;
    test_round_trip;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_code_pipe.md
Name: gray_code_pipe

Overview:
Parametrised, pipelined, bidirectional Gray/binary code converter with valid/ready handshakes on both sides.
- Each transaction carries a mode bit: Gray-to-binary (prefix-XOR, split across pipeline stages MSB-chunk first) or binary-to-Gray.
- Generalises the team's fixed 4-bit combinational Gray-to-binary converter.
- Sits between counter/encoder logic and datapath consumers that apply backpressure.

Parameters:
WIDTH, 8, data width in bits (>=2)
STAGES, 2, pipeline register stages (1..WIDTH); fixed latency in cycles
CHUNK, ceil(WIDTH/STAGES), derived localparam; bits resolved per stage in Gray-to-binary mode

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input word valid
in_ready  out  1  converter can accept a word this cycle
in_data  in  WIDTH  input code word
in_mode  in  1  0 = Gray-to-binary, 1 = binary-to-Gray
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts output this cycle
out_data  out  WIDTH  converted word
out_mode  out  1  mode bit travelling with out_data
busy  out  1  any pipeline stage holds a valid word

Behaviour:
- Reset (async assert, sync-released by clk edge):
  - All stage valid bits = 0, stage data/mode = 0.
  - out_valid = 0, out_data = 0, out_mode = 0, busy = 0.
  - in_ready = 1 once rst is low.
- Handshake:
  - Input transfer on in_valid & in_ready.
  - Output transfer on out_valid & out_ready.
  - While out_valid = 1 and out_ready = 0, out_data/out_mode hold stable.
- Pipeline: STAGES registers s0..s(STAGES-1); the last stage drives the outputs.
  - Stage k advances when it is empty or stage k+1 advances. The last stage advances when empty or out_ready = 1.
  - in_ready = stage 0 advances. This is combinational from out_ready through the chain, with no bubbles: full throughput of 1 word/cycle with out_ready held high.
  - Latency: a word accepted at edge n appears with out_valid = 1 after edge n+STAGES-1. Equivalently, STAGES cycles from the accept cycle to the first cycle the word is presented.
- Order is preserved. Mixed-mode streams are allowed back-to-back with no flush.
- Gray-to-binary (mode 0):
  - b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i].
  - Stage k resolves bits [WIDTH-1-k*CHUNK : max(0, WIDTH-(k+1)*CHUNK)]. It uses the lowest resolved bit from stage k-1 as the carry-in. Unresolved bits pass through as raw Gray.
  - If WIDTH is not a multiple of STAGES, the last stage takes the short chunk. A stage with no bits left is a pure register.
- Binary-to-Gray (mode 1):
  - g = b ^ (b >> 1), computed entirely in stage 0. Remaining stages are pure registers, so latency equals mode 0.
- Simultaneous events:
  - A full pipeline with out_ready = 1 and in_valid = 1 accepts and emits in the same cycle.
  - in_valid while in_ready = 0: word not taken. The source must hold it, which is standard valid/ready.
- Reset mid-operation: all in-flight words are discarded, with no partial output. After release the first accepted word starts the latency count afresh.
- busy = OR of all stage valid bits. It may be used for drain/idle detection.
- Width rules:
  - All XORs are WIDTH bits.
  - The shift in mode 1 is logical, with the MSB copied through unchanged.
  - No arithmetic overflow is possible.

Decomposition:
- Shared package gray_pkg:
  - localparam MODE_G2B = 1'b0, MODE_B2G = 1'b1.
  - Pure functions gray2bin_full(WIDTH) and bin2gray(WIDTH), used by the bench as the reference model.
- One natural sub-module: gray_pipe_stage.
  - Parameters: WIDTH, HI, LO.
  - Contents: valid/data/mode register, local advance logic, chunked prefix-XOR for its bit range, optional binary-to-Gray enable (stage 0 only).
- Top level: generate-loop of STAGES instances plus the in_ready/busy glue.

Test Plan:
- WIDTH=4, STAGES=2, mode 0, out_ready=1, back-to-back Gray words 1110, 0100, 0111, 1010, 1000. Required outputs in order, 2 cycles after each accept, one per cycle: 1011, 0111, 0101, 1100, 1111.
- WIDTH=4, STAGES=2, mode 1, inputs 1011 then 1111 -> 1110 then 1000, with out_mode = 1 on both.
- Backpressure: fill the pipe (WIDTH=8, STAGES=3) with out_ready=0.
  - in_ready must drop after exactly 3 accepts.
  - out_data stays stable.
  - Raising out_ready drains the words in order with no loss or duplication.
- Mixed modes alternating every cycle, random WIDTH=8 data, random out_ready (50%) over 1000 words. Every output must match the gray_pkg model for its mode, in order.
- Reset asserted with 2 words in flight:
  - out_valid and busy go 0 immediately (asynchronous), out_data = 0.
  - After release, the next word 0xFF (mode 0) yields 0xAA after STAGES cycles.
- Edge parameters:
  - WIDTH=5, STAGES=2 (uneven chunk) and WIDTH=4, STAGES=4, exhaustive 0..2^WIDTH-1 in both modes against the model.
  - Round trip: bin->Gray output fed back as a Gray->bin input reproduces the original value.
